// File: rtl/hamming_tx_scheduler.sv
// Round-robin, burst-limited arbiter feeding one shared SECDED(16,11) encoder.
// The output register holds each codeword on a valid/ready port and can carry one injected bit flip.
module hamming_tx_scheduler #(
    parameter int N_REQ     = 2,
    parameter int BURST_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [11*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 inj_en,
    input  logic [3:0]           inj_pos,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_code,
    output logic [1:0]           out_src,
    output logic                 out_inj,
    output logic [15:0]          sent_count
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]  holder_q, holder_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic [15:0] out_code_q, out_code_d;
    logic [1:0]  out_src_q, out_src_d;
    logic        out_inj_q, out_inj_d;
    logic [15:0] sent_count_q, sent_count_d;

    logic        holder_ok, end_burst, grant_found;
    logic [1:0]  eff_ptr, grant, idx;
    logic [10:0] sel_data;
    logic [15:0] code;

    function automatic logic [15:0] secded_encode(input logic [10:0] d);
        logic [15:0] c;
        c       = '0;
        c[3]    = d[0];
        c[5]    = d[1];
        c[6]    = d[2];
        c[7]    = d[3];
        c[15:9] = d[10:4];
        c[1]    = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
        c[2]    = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
        c[4]    = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        c[8]    = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        c[0]    = ^c[15:1];
        return c;
    endfunction

    function automatic logic bit_at(input logic [N_REQ-1:0] v, input logic [1:0] i);
        logic r;
        r = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (i == 2'(k)) r = v[k];
        end
        return r;
    endfunction

    function automatic logic [1:0] wrap_inc(input logic [1:0] i);
        logic [2:0] s;
        s = {1'b0, i} + 3'd1;
        return (s >= 3'(N_REQ)) ? 2'd0 : s[1:0];
    endfunction

    always_comb begin
        // burst_cnt of zero means no burst is in progress
        holder_ok = (burst_cnt_q != 4'd0) && (burst_cnt_q < 4'(BURST_MAX))
                    && bit_at(req_valid, holder_q);
        end_burst = (state_q == IDLE) && (burst_cnt_q != 4'd0) && !holder_ok;
        eff_ptr   = end_burst ? wrap_inc(holder_q) : rr_ptr_q;

        grant       = '0;
        grant_found = 1'b0;
        idx         = eff_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && bit_at(req_valid, idx)) begin
                grant       = idx;
                grant_found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        if (holder_ok) begin
            grant       = holder_q;
            grant_found = 1'b1;
        end

        sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant == 2'(k)) sel_data = req_data[11*k +: 11];
        end
        code = secded_encode(sel_data) ^ ({15'd0, inj_en} << inj_pos);
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        holder_d     = holder_q;
        burst_cnt_d  = burst_cnt_q;
        out_code_d   = out_code_q;
        out_src_d    = out_src_q;
        out_inj_d    = out_inj_q;
        sent_count_d = sent_count_q;
        req_ready    = '0;

        case (state_q)
            IDLE: begin
                if (end_burst) begin
                    rr_ptr_d    = wrap_inc(holder_q);
                    burst_cnt_d = 4'd0;
                end
                for (int k = 0; k < N_REQ; k++) begin
                    req_ready[k] = grant_found && (grant == 2'(k));
                end
                if (grant_found) begin
                    out_code_d = code;
                    out_src_d  = grant;
                    out_inj_d  = inj_en;
                    state_d    = SEND;
                    if (holder_ok) begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                    end else begin
                        holder_d    = grant;
                        burst_cnt_d = 4'd1;
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    sent_count_d = sent_count_q + 16'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            holder_q     <= '0;
            burst_cnt_q  <= '0;
            out_code_q   <= '0;
            out_src_q    <= '0;
            out_inj_q    <= 1'b0;
            sent_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            holder_q     <= holder_d;
            burst_cnt_q  <= burst_cnt_d;
            out_code_q   <= out_code_d;
            out_src_q    <= out_src_d;
            out_inj_q    <= out_inj_d;
            sent_count_q <= sent_count_d;
        end
    end

    assign out_valid  = (state_q == SEND);
    assign out_code   = out_code_q;
    assign out_src    = out_src_q;
    assign out_inj    = out_inj_q;
    assign sent_count = sent_count_q;

endmodule

// File: doc/hamming_tx_scheduler.md
# hamming_tx_scheduler

Shares one SECDED(16,11) Hamming encode stage among `N_REQ` message sources.
- Round-robin arbitration with bounded bursts picks one source at a time.
- The selected 11-bit word is registered as a 16-bit codeword tagged with the source id.
- The codeword is held on a valid/ready output until the downstream channel accepts it.
- A configuration port can inject one bit flip, to exercise the downstream self-correcting decoder.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 2..4.
- `BURST_MAX`, default 4: maximum consecutive words granted to one requester, legal range 1..15.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, `N_REQ`: bit i means requester i presents a word.
- `req_data`, in, `11*N_REQ`: requester i word is `req_data[11*i +: 11]`.
- `req_ready`, out, `N_REQ`: one-hot accept, combinational from state and `req_valid`.
- `inj_en`, in, 1: flip one codeword bit on the next accepted word.
- `inj_pos`, in, 4: codeword bit index to flip; 0..15 are all legal.
- `out_valid`, out, 1: codeword register holds an unsent word.
- `out_ready`, in, 1: downstream accepts the word.
- `out_code`, out, 16: codeword; bit k is Hamming position k.
- `out_src`, out, 2: index of the requester that produced `out_code`.
- `out_inj`, out, 1: set if `out_code` carries an injected flip.
- `sent_count`, out, 16: number of completed output handshakes, wraps modulo 2^16.

## Operation
- Codeword layout, with d = accepted word and ^ = XOR:
  - Data positions: pos3=d0, pos5=d1, pos6=d2, pos7=d3, pos9..pos15=d4..d10.
  - p1 (pos1) = d0^d1^d3^d4^d6^d8^d10.
  - p2 (pos2) = d0^d2^d3^d5^d6^d9^d10.
  - p3 (pos4) = d1^d2^d3^d7^d8^d9^d10.
  - p4 (pos8) = d4^d5^d6^d7^d8^d9^d10.
  - p0 (pos0) = XOR of all 11 data bits and p1..p4 (overall parity).
- Injection: if `inj_en`=1 in the accept cycle, bit `inj_pos` of the computed codeword is inverted before it is registered, and `out_inj` is set to 1; otherwise `out_inj`=0. Injection is sampled per word; there is no sticky state.
- FSM states:
  - IDLE: `out_valid`=0.
    - If the holder is valid and `burst_cnt`<`BURST_MAX`, grant the holder.
    - Otherwise grant the first valid index found scanning from `rr_ptr` upward, modulo `N_REQ`.
    - `req_ready` is asserted for the granted index only.
    - On accept: load `out_code`/`out_src`/`out_inj` and go to SEND.
    - Holder bookkeeping on accept:
      - Same holder: `burst_cnt`+1.
      - New holder: holder=grant, `burst_cnt`=1, and the previous holder's burst ends.
    - When a burst ends, either because the limit was reached or because the holder was not valid in IDLE, set `rr_ptr` = (holder+1) mod `N_REQ` and clear `burst_cnt`.
    - If no requester is valid, stay in IDLE.
  - SEND: `out_valid`=1, `req_ready`=0, output registers stable.
    - On `out_ready`: `sent_count`+1 and go to IDLE.
    - Without `out_ready`: hold indefinitely.
- `req_ready` is never asserted while in SEND. At most one `req_ready` bit is ever high.
- Reset values: state IDLE, `rr_ptr`=0, holder=0, `burst_cnt`=0, `out_valid`=0, `out_code`=0, `out_src`=0, `out_inj`=0, `sent_count`=0.

## Timing
- Accept-to-output latency: `out_valid` rises the cycle after the `req_valid`&`req_ready` handshake.
- Throughput: at most one word per 2 cycles (accept, then send).
- `req_valid` may drop at any time when it is not handshaken. No word is captured without `req_ready`.
- `out_valid` stays high and `out_code`/`out_src`/`out_inj` stay constant until the `out_ready` handshake.
- Reset asserted mid-SEND drops `out_valid` the next cycle; the held word is lost. `rst` overrides all other inputs.
- Holder at `burst_cnt`=`BURST_MAX` with another requester valid: the other requester is granted in the next IDLE. If the holder is the only valid requester, it is re-granted and a new burst starts with `burst_cnt`=1.
- `sent_count` wraps from 16'hFFFF to 16'h0000 without a flag.
- `out_src` for unused requester indices never appears.

## Test plan
- Encoding values, single requester 0, no injection, `out_ready`=1: data 11'h000 gives `out_code` 16'h0000; 11'h7FF gives 16'hFFFF; 11'h001 gives 16'h000F. Each appears exactly 1 cycle after accept, with `out_src`=0.
- Backpressure: `out_ready` held at 0 for 10 cycles after a word is loaded → `out_valid` stays 1, `out_code` is unchanged, every `req_ready` bit is 0, and `sent_count` increments only once after release.
- Round-robin and burst limit: `N_REQ`=2, `BURST_MAX`=4, both requesters always valid → `out_src` sequence 0,0,0,0,1,1,1,1,0,...
- Early burst end: holder drops `req_valid` after 2 words → the next grant goes to the other requester, and `rr_ptr` advances.
- Injection: data 11'h000 with `inj_en`=1, `inj_pos`=5 → `out_code` 16'h0020 and `out_inj`=1. The next word with `inj_en`=0 → `out_inj`=0.
- Reset: assert `rst` during SEND → next cycle `out_valid`=0, `sent_count`=0, and the first subsequent grant goes to requester 0.
